ece453_button_conditioner: RTL
==============================

# ece453_button_conditioner

Input front end for the LED-walk FSM. It takes the raw board pushbutton and direction slide switch and produces the clean, clock-domain-safe `button` and `direction` signals that the FSM consumes. For each input it synchronizes, then debounces. For the button it also converts a held press into a single-cycle step pulse plus optional auto-repeat steps. The block sits between the board pins and the FSM's `button`/`direction` ports.

## Interface
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth, legal range 2–3.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- `HOLD_CYCLES`, default 25000000: cycles a press must be held before auto-repeat starts; 0 disables auto-repeat.
- `REPEAT_CYCLES`, default 10000000: period between auto-repeat pulses; must be ≥ 2.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset (`RESET_ACTIVE`).
- `btn_raw_n` in 1: raw pushbutton, asynchronous, active-low.
- `dir_raw` in 1: raw slide switch, asynchronous; 1 = `LEFT`, 0 = `RIGHT`.
- `button` out 1: single-cycle step pulse; `BTN_PRESSED` for exactly one cycle per accepted press or repeat.
- `button_level` out 1: debounced held state of the button (1 = held).
- `direction` out 1: debounced switch level, encoded `LEFT`/`RIGHT`.

## Operation
- Each raw input passes through a `SYNC_STAGES` synchronizer, then a debouncer.
- Debouncer behaviour:
  - Keeps a stable level and a counter.
  - The counter clears whenever the synchronized input equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the input still differs, the stable level flips and the counter clears.
  - Any bounce back to the stable level before that point restarts the count from 0.
- Button FSM states and transitions:
  - `IDLE`: `button_level`=0. A debounced press goes to `PRESSED` and emits a `button` pulse that cycle.
  - `PRESSED`: a debounced release goes to `IDLE`. If `HOLD_CYCLES`≠0 and the hold counter reaches `HOLD_CYCLES-1`, go to `REPEAT` and emit a pulse.
  - `REPEAT`: emit a pulse every `REPEAT_CYCLES` cycles. A debounced release goes to `IDLE` with no pulse.
- Release never produces a pulse.
- A release and a repeat-timer expiry in the same cycle resolve as release: no pulse.
- `direction` is a pure debounced level with no pulse logic. A direction change never affects `button`.
- Counters saturate; none wraps. Counter widths are `$clog2` of the largest parameter they compare against, plus 1.

## Timing
- Reset values:
  - `button`=0, `button_level`=0.
  - `direction`=`RIGHT`.
  - All synchronizer flops at the idle pin level: `btn_raw_n` flops = 1, `dir_raw` flops = 0.
  - All counters 0, button FSM = `IDLE`.
- Reset asserted mid-operation clears everything immediately. No pulse is emitted on reset exit, even if the button is held.
  - A held button after reset must first be accepted as a new press, which needs the full debounce latency.
- Latency: with a raw edge sampled at clock edge 0 and held stable, the debounced level (and the `button` pulse, registered) changes at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- Auto-repeat timing:
  - The first repeat pulse comes `HOLD_CYCLES` cycles after the press pulse.
  - Subsequent repeat pulses come every `REPEAT_CYCLES` cycles.
- All outputs are registered, with no combinational path from any input.
- `button` is never high for two consecutive cycles.

## Structure
- Shared constants come from the existing `ece453_fsm_example.vh` header: `BTN_PRESSED`, `BTN_NOT_PRESSED`, `LEFT`, `RIGHT`, `RESET_ACTIVE`.
- Add the button-FSM state encoding (`BC_IDLE`, `BC_PRESSED`, `BC_REPEAT`) to a new header, `ece453_button_conditioner.vh`.
- Sub-module `ece453_debounce`:
  - Parameters: `SYNC_STAGES`, `DEBOUNCE_CYCLES`, `RESET_LEVEL`.
  - Ports: `clk`, `reset`, `raw`, `level`.
  - Instantiated twice, once for the button and once for the direction switch.

## Test plan
All scenarios use `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=16, `REPEAT_CYCLES`=8.

1. Reset with idle pins, then release reset:
   - Required: `button`=0, `button_level`=0, `direction`=`RIGHT` throughout.
   - Required: no pulse over 20 cycles.
2. Drive `btn_raw_n` low at edge 0 and hold it:
   - Required: `button` high only in the cycle after edge 6.
   - Required: `button_level`=1 from edge 6 onward.
3. Bounce `btn_raw_n` low/high on alternating 2-cycle intervals for 20 cycles, then return it high:
   - Required: no `button` pulse.
   - Required: `button_level` stays 0.
4. Hold the press for 40 cycles after acceptance:
   - Required: pulses at edges 6, 22, 30 and 38.
   - Required: releasing at edge 40 produces no pulse, and `button_level` drops at edge 46.
5. Toggle `dir_raw` to 1 for 3 cycles, then toggle it to 1 and hold:
   - Required: the 3-cycle toggle is ignored.
   - Required: the held toggle gives `direction`=`LEFT` exactly 6 edges after the hold begins.
6. Assert `reset` while the FSM is in `REPEAT`, then deassert it with the button still held:
   - Required: outputs return to their reset values immediately.
   - Required: the next pulse comes 6 edges after reset deassertion.

Source files
------------

// File: rtl/ece453_button_conditioner_pkg.sv
// Shared constants and button-FSM state encoding for the
// LED-walk input front end.
package ece453_button_conditioner_pkg;

    localparam logic BTN_PRESSED     = 1'b1;
    localparam logic BTN_NOT_PRESSED = 1'b0;
    localparam logic LEFT            = 1'b1;
    localparam logic RIGHT           = 1'b0;
    localparam logic RESET_ACTIVE    = 1'b1;

    typedef enum logic [1:0] {
        BC_IDLE    = 2'd0,
        BC_PRESSED = 2'd1,
        BC_REPEAT  = 2'd2
    } bc_state_t;

endpackage

// File: rtl/ece453_debounce.sv
// Synchronizer chain followed by a stable-count debouncer for one
// asynchronous board input.
module ece453_debounce
    import ece453_button_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[SYNC_STAGES-1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset == RESET_ACTIVE) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/ece453_button_conditioner.sv
// Pushbutton and direction-switch front end: debounced levels plus a
// single-cycle step pulse with optional auto-repeat while held.
module ece453_button_conditioner
    import ece453_button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_n,
    input  logic dir_raw,
    output logic button,
    output logic button_level,
    output logic direction
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW = $clog2(MAXC) + 1;
    localparam logic [TW-1:0] HOLD_LAST =
        TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_CYCLES - 1);

    logic      btn_lvl_n;
    logic      dir_lvl;
    logic      pressed;
    bc_state_t state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
    logic      button_q, button_d;
    logic      level_q, level_d;
    logic      dir_q;

    ece453_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
    ) u_btn_db (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_raw_n),
        .level(btn_lvl_n)
    );

    ece453_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (RIGHT)
    ) u_dir_db (
        .clk  (clk),
        .reset(reset),
        .raw  (dir_raw),
        .level(dir_lvl)
    );

    assign pressed = ~btn_lvl_n;
    assign tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + TW'(1);

    // Release is checked first so it wins over a same-cycle timer expiry.
    always_comb begin
        state_d  = state_q;
        tmr_d    = '0;
        button_d = BTN_NOT_PRESSED;
        unique case (state_q)
            BC_IDLE: begin
                if (pressed) begin
                    state_d  = BC_PRESSED;
                    button_d = BTN_PRESSED;
                end
            end
            BC_PRESSED: begin
                if (!pressed) begin
                    state_d = BC_IDLE;
                end else if (HOLD_CYCLES != 0 && tmr_q == HOLD_LAST) begin
                    state_d  = BC_REPEAT;
                    button_d = BTN_PRESSED;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            BC_REPEAT: begin
                if (!pressed) begin
                    state_d = BC_IDLE;
                end else if (tmr_q == REP_LAST) begin
                    button_d = BTN_PRESSED;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: state_d = BC_IDLE;
        endcase
        level_d = (state_d != BC_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset == RESET_ACTIVE) begin
            state_q  <= BC_IDLE;
            tmr_q    <= '0;
            button_q <= BTN_NOT_PRESSED;
            level_q  <= 1'b0;
            dir_q    <= RIGHT;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            button_q <= button_d;
            level_q  <= level_d;
            dir_q    <= dir_lvl;
        end
    end

    assign button       = button_q;
    assign button_level = level_q;
    assign direction    = dir_q;

endmodule
